// File: rtl/wb_uart_tx_if.sv
// Write-back stream interface between the processor unit and the UART trace block.
//   we  : write-back strobe, 1 = rwd valid this cycle
//   rwd : write-back data, DW bits
// master drives the stream (processor side); slave receives it (wb_uart_tx).
interface wb_uart_tx_if #(
   parameter int unsigned DW = 32
) ();
   logic          we;
   logic [DW-1:0] rwd;

   modport master (output we, output rwd);
   modport slave  (input we, input rwd);
endinterface

// File: rtl/wb_uart_tx.sv
// Register write-back tracer: every word written back by the processor is queued in a small
// FIFO and shipped out on a UART line as DW/8 8N1 frames, most-significant byte first.
// The CPU is never stalled; words arriving into a full FIFO are dropped and flagged.
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active low
//   wb    : write-back stream (we, rwd), slave side
//   tx    : UART serial line, idles high, registered
//   busy  : frame in progress or FIFO non-empty, registered
//   ovf   : sticky overflow flag, cleared only by reset
//   level : FIFO occupancy, 0..DEPTH
module wb_uart_tx #(
   parameter int unsigned DW           = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                     clk,
   input  logic                     rst,
   wb_uart_tx_if.slave              wb,
   output logic                     tx,
   output logic                     busy,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned NB  = DW / 8;
   localparam int unsigned BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [DW-1:0]  mem_q [DEPTH];
   logic [DW-1:0]  mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           ovf_q, ovf_d;
   state_e         state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [BCW-1:0] byte_q, byte_d;
   logic [DW-1:0]  shreg_q, shreg_d;
   logic           tx_q, tx_d;
   logic           busy_q, busy_d;

   logic           full, pop, push, baud_last;
   logic [7:0]     cur_byte;

   // FIFO: a pop frees a slot in the same edge, so a full FIFO still accepts a push then.
   always_comb begin
      full     = (count_q == (AW+1)'(DEPTH));
      pop      = (state_q == StIdle) && (count_q != '0);
      push     = wb.we && (!full || pop);
      ovf_d    = ovf_q | (wb.we & full & ~pop);
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = wb.rwd;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Serialiser FSM. The current byte always sits in the top 8 bits of the shift register.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shreg_d   = shreg_q;
      baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               shreg_d = mem_q[rd_ptr_q];
               byte_d  = BCW'(NB - 1);
               baud_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_last) begin
               baud_d = '0;
               if (byte_q != '0) begin
                  byte_d  = byte_q - 1'b1;
                  shreg_d = shreg_q << 8;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are computed from next-state so the registered tx lines up with the state.
   always_comb begin
      cur_byte = shreg_d[DW-1 -: 8];
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = cur_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != StIdle) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         shreg_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign tx    = tx_q;
   assign busy  = busy_q;
   assign ovf   = ovf_q;
   assign level = count_q;
endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx (DW=16, DEPTH=4, CLKS_PER_BIT=4). Stimulus pushes expected bytes into a
// scoreboard queue; an independent monitor decodes the tx line and pops/compares each frame.
module tb_wb_uart_tx;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CPB   = 4;
   localparam int          NOGAP = 1000000;

   typedef struct {
      logic [7:0] data;
      int         gap;   // idle-high cycles expected before this frame; -1 = unchecked
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx, busy, ovf;
   logic [2:0] level;
   int         errors = 0;
   int         checks = 0;
   exp_t       sb[$];

   wb_uart_tx_if #(.DW(DW)) wb ();

   wb_uart_tx #(.DW(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst   (rst),
      .wb    (wb),
      .tx    (tx),
      .busy  (busy),
      .ovf   (ovf),
      .level (level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_word(input logic [15:0] w, input int gap0);
      exp_t e;
      e.data = w[15:8];
      e.gap  = gap0;
      sb.push_back(e);
      e.data = w[7:0];
      e.gap  = 0;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      wb.we  = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      sb.delete();
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((busy !== 1'b0) && (n < budget)) begin
         tick();
         n++;
      end
      check({name, "_drain_in_time"}, 32'(n < budget), 1);
      tick();
      tick();
      check({name, "_all_frames_seen"}, sb.size(), 0);
   endtask

   // Monitor: samples tx on falling edges, checks every sample of every bit period.
   initial begin : monitor
      int         gap;
      int         k;
      logic [7:0] d;
      bit         shape_ok;
      bit         aborted;
      exp_t       e;
      gap = NOGAP;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            gap = NOGAP;
         end else if (tx !== 1'b0) begin
            if (gap < NOGAP) gap++;
         end else begin
            d        = '0;
            shape_ok = 1'b1;
            aborted  = 1'b0;
            for (int s = 0; s < 10 * CPB; s++) begin
               if (s != 0) @(negedge clk);
               if (rst !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               k = s / CPB;
               if (k == 0) begin
                  if (tx !== 1'b0) shape_ok = 1'b0;
               end else if (k == 9) begin
                  if (tx !== 1'b1) shape_ok = 1'b0;
               end else if ((s % CPB) == 0) begin
                  d[k-1] = tx;
               end else if (tx !== d[k-1]) begin
                  shape_ok = 1'b0;
               end
            end
            if (aborted) begin
               gap = NOGAP;
            end else begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got byte %02h, expected no frame", d);
               end else begin
                  e = sb.pop_front();
                  check("frame_byte", 32'(d), 32'(e.data));
                  check("frame_shape", 32'(shape_ok), 1);
                  if (e.gap >= 0) check("idle_gap", gap, e.gap);
               end
               gap = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int bad_tx, bad_busy, bad_lvl;
      wb.we  = 1'b0;
      wb.rwd = '0;

      // 1: single word, exact timing
      do_reset();
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      check("rst_level", level, 0);
      wb.we  = 1'b1;
      wb.rwd = 16'hA53C;
      sb_word(16'hA53C, -1);
      tick();
      wb.we = 1'b0;
      check("t1_tx_at_push", tx, 1);
      check("t1_level_at_push", level, 1);
      check("t1_busy_at_push", busy, 1);
      tick();
      check("t1_tx_start", tx, 0);
      check("t1_level_after_pop", level, 0);
      repeat (79) tick();
      check("t1_busy_last_stop", busy, 1);
      check("t1_tx_last_stop", tx, 1);
      tick();
      check("t1_busy_end", busy, 0);
      check("t1_ovf", ovf, 0);
      check("t1_all_frames_seen", sb.size(), 0);

      // 2: overflow
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         wb.we  = 1'b1;
         wb.rwd = 16'(i);
         if (i <= 5) sb_word(16'(i), (i == 1) ? -1 : 1);
         tick();
         if (i == 5) begin
            check("t2_level_full", level, 4);
            check("t2_ovf_before_drop", ovf, 0);
         end
      end
      wb.we = 1'b0;
      check("t2_level_after_drop", level, 4);
      check("t2_ovf_set", ovf, 1);
      drain("t2", 600);
      check("t2_ovf_sticky", ovf, 1);
      check("t2_level_empty", level, 0);

      // 3: push into a full FIFO at the pop edge
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         wb.we  = 1'b1;
         wb.rwd = 16'h1100 + 16'(i);
         sb_word(16'h1100 + 16'(i), (i == 1) ? -1 : 1);
         tick();
      end
      wb.we = 1'b0;
      repeat (77) tick();
      check("t3_level_full_before", level, 4);
      wb.we  = 1'b1;
      wb.rwd = 16'hBEEF;
      sb_word(16'hBEEF, 1);
      tick();
      wb.we = 1'b0;
      check("t3_level_at_pop_push", level, 4);
      check("t3_ovf_clear", ovf, 0);
      drain("t3", 700);
      check("t3_ovf_still_clear", ovf, 0);

      // 4: reset in the DATA state of the second byte
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         wb.we  = 1'b1;
         wb.rwd = 16'(i);
         tick();
      end
      begin
         exp_t e;
         e.data = 8'h00;
         e.gap  = -1;
         sb.push_back(e);
      end
      wb.we = 1'b0;
      repeat (54) tick();
      check("t4_tx_before_rst", tx, 0);
      check("t4_level_before_rst", level, 4);
      check("t4_ovf_before_rst", ovf, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("t4_tx_after_rst", tx, 1);
      check("t4_level_after_rst", level, 0);
      check("t4_busy_after_rst", busy, 0);
      check("t4_ovf_after_rst", ovf, 0);
      check("t4_first_byte_seen", sb.size(), 0);
      bad_tx = 0;
      repeat (200) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) bad_tx++;
      end
      check("t4_quiet_cycles_bad", bad_tx, 0);

      // 5: two words back to back, gaps checked by the monitor
      do_reset();
      wb.we  = 1'b1;
      wb.rwd = 16'h8001;
      sb_word(16'h8001, -1);
      tick();
      wb.rwd = 16'h7EFF;
      sb_word(16'h7EFF, 1);
      tick();
      wb.we = 1'b0;
      drain("t5", 400);

      // 6: long idle
      do_reset();
      bad_tx   = 0;
      bad_busy = 0;
      bad_lvl  = 0;
      repeat (1000) begin
         tick();
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         if (level !== 3'd0) bad_lvl++;
      end
      check("t6_tx_not_idle_cycles", bad_tx, 0);
      check("t6_busy_cycles", bad_busy, 0);
      check("t6_level_cycles", bad_lvl, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
